// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and zero-register helper for regfile_sb
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int unsigned ZERO_ADDR = 0;

    function automatic logic is_zero_reg(input int unsigned addr, input logic zero_reg);
        return zero_reg && addr == ZERO_ADDR;
    endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, writeback, issue and flush signals of the register file
interface regfile_sb_if #(
    parameter int DATA_W = regfile_pkg::DEF_DATA_W,
    parameter int ADDR_W = regfile_pkg::DEF_ADDR_W
);
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              busy1;
    logic              busy2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic              flush;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output ra1, ra2, we, wa, wd, iss_valid, iss_addr, flush,
        input  rd1, rd2, busy1, busy2, pend_cnt
    );
    modport slave (
        input  ra1, ra2, we, wa, wd, iss_valid, iss_addr, flush,
        output rd1, rd2, busy1, busy2, pend_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, pending counter and busy read masking
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy, busy_nxt;
    logic inc, dec;

    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (set_en) busy_nxt[set_addr] = 1'b1;
        if (flush) busy_nxt = '0;
    end

    // A clear on the address being re-issued is not a real 1->0 transition
    assign inc = set_en && !busy[set_addr];
    assign dec = clr_en && busy[clr_addr] && !(set_en && set_addr == clr_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= flush ? '0 : pend_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
        end
    end

    assign busy1 = busy[ra1] && !(BYPASS != 0 && clr_en && clr_addr == ra1 && !(set_en && set_addr == ra1));
    assign busy2 = busy[ra2] && !(BYPASS != 0 && clr_en && clr_addr == ra2 && !(set_en && set_addr == ra2));
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R1W register file with write bypass, optional zero register and
// a busy scoreboard for RAW hazard detection on long-latency results
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic        clk,
    input logic        rst_n,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic wr_en, iss_en;

    // Reset masks writes and issues, which also keeps the bypass path quiet
    assign wr_en  = rst_n && bus.we && !is_zero_reg(32'(bus.wa), ZERO_REG != 0);
    assign iss_en = rst_n && bus.iss_valid && !is_zero_reg(32'(bus.iss_addr), ZERO_REG != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    assign bus.rd1 = is_zero_reg(32'(bus.ra1), ZERO_REG != 0) ? '0 :
                     (BYPASS != 0 && wr_en && bus.wa == bus.ra1) ? bus.wd : mem[bus.ra1];
    assign bus.rd2 = is_zero_reg(32'(bus.ra2), ZERO_REG != 0) ? '0 :
                     (BYPASS != 0 && wr_en && bus.wa == bus.ra2) ? bus.wd : mem[bus.ra2];

    regfile_scoreboard #(.ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_en),
        .set_addr (bus.iss_addr),
        .clr_en   (wr_en),
        .clr_addr (bus.wa),
        .flush    (bus.flush),
        .ra1      (bus.ra1),
        .ra2      (bus.ra2),
        .busy1    (bus.busy1),
        .busy2    (bus.busy2),
        .pend_cnt (bus.pend_cnt)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: checks a bypassing and a non-bypassing regfile_sb against a
// behavioural register/busy model plus hand-computed directed expectations
module tb_regfile_sb;
    logic clk = 1'b0, clk_en = 1'b1, rst_n = 1'b1;
    logic [4:0]  ra1, ra2, wa, iss_addr;
    logic [31:0] wd;
    logic        we, iss_valid, flush;
    int checks = 0, errors = 0;
    logic [31:0] m_reg [32];
    logic [31:0] m_busy;

    regfile_sb_if i0 ();
    regfile_sb_if i1 ();

    regfile_sb #(.BYPASS(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
    regfile_sb #(.BYPASS(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

    assign i0.ra1 = ra1;  assign i1.ra1 = ra1;
    assign i0.ra2 = ra2;  assign i1.ra2 = ra2;
    assign i0.we = we;    assign i1.we = we;
    assign i0.wa = wa;    assign i1.wa = wa;
    assign i0.wd = wd;    assign i1.wd = wd;
    assign i0.iss_valid = iss_valid;  assign i1.iss_valid = iss_valid;
    assign i0.iss_addr = iss_addr;    assign i1.iss_addr = iss_addr;
    assign i0.flush = flush;  assign i1.flush = flush;

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: registers, busy set and popcount as the pending count
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_reg[i] <= 32'd0;
            m_busy <= 32'd0;
        end else begin
            if (we && wa != 0) m_reg[wa] <= wd;
            m_busy <= flush ? 32'd0 :
                      ((m_busy & ~((we && wa != 0) ? (32'd1 << wa) : 32'd0)) |
                       ((iss_valid && iss_addr != 0) ? (32'd1 << iss_addr) : 32'd0));
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input logic byp);
        if (ra == 0) return 32'd0;
        if (byp && rst_n && we && wa == ra) return wd;
        return m_reg[ra];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] ra, input logic byp);
        if (byp && rst_n && we && wa == ra && ra != 0 && !(iss_valid && iss_addr == ra)) return 32'd0;
        return 32'(m_busy[ra]);
    endfunction

    always @(negedge clk) begin
        chk("m_rd1_byp", i0.rd1, exp_rd(ra1, 1'b1));
        chk("m_rd2_byp", i0.rd2, exp_rd(ra2, 1'b1));
        chk("m_busy1_byp", 32'(i0.busy1), exp_busy(ra1, 1'b1));
        chk("m_busy2_byp", 32'(i0.busy2), exp_busy(ra2, 1'b1));
        chk("m_pend_byp", 32'(i0.pend_cnt), 32'($countones(m_busy)));
        chk("m_rd1_nobyp", i1.rd1, exp_rd(ra1, 1'b0));
        chk("m_rd2_nobyp", i1.rd2, exp_rd(ra2, 1'b0));
        chk("m_busy1_nobyp", 32'(i1.busy1), exp_busy(ra1, 1'b0));
        chk("m_busy2_nobyp", 32'(i1.busy2), exp_busy(ra2, 1'b0));
        chk("m_pend_nobyp", 32'(i1.pend_cnt), 32'($countones(m_busy)));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ra1 = 0; ra2 = 0; wa = 0; iss_addr = 0; wd = 0;
        we = 0; iss_valid = 0; flush = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_pend", 32'(i0.pend_cnt), 32'd0);
        // r5 written and issued, then async reset with the clock stopped
        we = 1; wa = 5; wd = 32'hDEADBEEF; iss_valid = 1; iss_addr = 5;
        step();
        we = 0; iss_valid = 0; ra1 = 5;
        #1;
        chk("pre_rst_rd1", i0.rd1, 32'hDEADBEEF);
        chk("pre_rst_busy1", 32'(i0.busy1), 32'd1);
        chk("pre_rst_pend", 32'(i0.pend_cnt), 32'd1);
        @(negedge clk);
        clk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_rd1", i0.rd1, 32'd0);
        chk("async_rst_busy1", 32'(i0.busy1), 32'd0);
        chk("async_rst_pend", 32'(i0.pend_cnt), 32'd0);
        we = 1; wa = 5; wd = 32'h11111111;
        #1;
        chk("rst_no_bypass", i0.rd1, 32'd0);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 we = 0; rst_n = 1'b1;
        #1;
        chk("rst_write_ignored", i0.rd1, 32'd0);
        // write r7 with same-cycle read on port 2
        ra2 = 7; we = 1; wa = 7; wd = 32'h12345678;
        #1;
        chk("bypass_rd2", i0.rd2, 32'h12345678);
        chk("nobypass_rd2", i1.rd2, 32'd0);
        step();
        we = 0;
        #1;
        chk("held_rd2_byp", i0.rd2, 32'h12345678);
        chk("held_rd2_nobyp", i1.rd2, 32'h12345678);
        // zero register ignores writes and issues
        ra1 = 0; we = 1; wa = 0; wd = 32'hFFFFFFFF; iss_valid = 1; iss_addr = 0;
        #1;
        chk("zero_rd1", i0.rd1, 32'd0);
        chk("zero_busy1", 32'(i0.busy1), 32'd0);
        step();
        we = 0; iss_valid = 0;
        #1;
        chk("zero_pend", 32'(i0.pend_cnt), 32'd0);
        // issue then writeback r3
        ra1 = 3; iss_valid = 1; iss_addr = 3;
        step();
        iss_valid = 0;
        #1;
        chk("iss_busy1", 32'(i0.busy1), 32'd1);
        chk("iss_pend", 32'(i0.pend_cnt), 32'd1);
        we = 1; wa = 3; wd = 32'hA5;
        #1;
        chk("wb_busy1_byp", 32'(i0.busy1), 32'd0);
        chk("wb_rd1_byp", i0.rd1, 32'hA5);
        chk("wb_busy1_nobyp", 32'(i1.busy1), 32'd1);
        chk("wb_rd1_nobyp", i1.rd1, 32'd0);
        step();
        we = 0;
        #1;
        chk("wb_pend", 32'(i0.pend_cnt), 32'd0);
        // collision: new producer beats writeback on r9
        ra1 = 9; iss_valid = 1; iss_addr = 9;
        step();
        we = 1; wa = 9; wd = 32'h99;
        #1;
        chk("coll_busy1", 32'(i0.busy1), 32'd1);
        chk("coll_rd1", i0.rd1, 32'h99);
        step();
        we = 0; iss_valid = 0;
        #1;
        chk("coll_busy_after", 32'(i0.busy1), 32'd1);
        chk("coll_pend", 32'(i0.pend_cnt), 32'd1);
        chk("coll_rd_after", i1.rd1, 32'h99);
        we = 1; wa = 9;
        step();
        we = 0;
        // r1, r2, r4 then flush with a competing issue
        foreach (m_reg[i]) if (i == 1 || i == 2 || i == 4) begin
            iss_valid = 1; iss_addr = 5'(i);
            step();
        end
        iss_valid = 0;
        #1;
        chk("three_pend", 32'(i0.pend_cnt), 32'd3);
        flush = 1; iss_valid = 1; iss_addr = 6; ra1 = 6;
        step();
        flush = 0; iss_valid = 0;
        #1;
        chk("flush_pend", 32'(i0.pend_cnt), 32'd0);
        chk("flush_busy1", 32'(i0.busy1), 32'd0);
        // set and clear on different addresses net to zero change
        iss_valid = 1; iss_addr = 10;
        step();
        iss_addr = 11; we = 1; wa = 10; wd = 32'h10;
        step();
        wa = 12;
        step();
        we = 0;
        #1;
        chk("net_zero_pend", 32'(i0.pend_cnt), 32'd1);
        iss_valid = 0;
        // every non-zero register busy
        for (int i = 1; i < 32; i++) begin
            iss_valid = 1; iss_addr = 5'(i);
            step();
        end
        iss_valid = 0;
        #1;
        chk("full_pend", 32'(i0.pend_cnt), 32'd31);
        // mixed traffic checked by the model
        for (int i = 0; i < 40; i++) begin
            we = (i % 3) != 0; wa = 5'((i * 7) % 32); wd = (i * 32'h01010101) ^ 32'hC3;
            iss_valid = (i % 2) == 1; iss_addr = 5'((i * 5 + 3) % 32);
            flush = (i == 25); ra1 = 5'((i * 7) % 32); ra2 = 5'((i * 5 + 3) % 32);
            step();
        end
        we = 0; iss_valid = 0; flush = 0;
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor register file for the single-cycle/multicycle MIPS datapath.
- Two combinational read ports and one synchronous write port.
- Write-to-read bypass in the same cycle, and a hardwired-zero register option.
- Per-register busy scoreboard with a pending-count counter, used by upcoming multicycle/pipelined control to detect RAW hazards on long-latency results.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 always reads 0; writes and issues to it are ignored.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports and the busy outputs.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ra1  in  ADDR_W  read address, port 1.
- ra2  in  ADDR_W  read address, port 2.
- rd1  out  DATA_W  read data, port 1 (combinational).
- rd2  out  DATA_W  read data, port 2 (combinational).
- busy1  out  1  register ra1 has an outstanding producer.
- busy2  out  1  register ra2 has an outstanding producer.
- we  in  1  write enable (writeback).
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- iss_valid  in  1  issue of an instruction that will later write iss_addr.
- iss_addr  in  ADDR_W  destination of the issued instruction.
- flush  in  1  clear all busy bits (pipeline flush).
- pend_cnt  out  ADDR_W+1  number of busy registers (registered).

Behaviour:
- Reset:
  - Asserting rst_n=0 clears immediately, independent of clk: all registers to 0, all busy bits to 0, pend_cnt to 0.
  - Consequently rd1, rd2, busy1 and busy2 read 0 during reset.
  - Writes, issues and flushes are ignored while rst_n=0.
  - Deasserting reset mid-operation leaves the state all-zero; there is no replay.
- Write:
  - On the rising edge with we=1, reg[wa] <= wd.
  - When ZERO_REG=1 and wa=0, the write is dropped.
  - When we=0, the contents are held.
- Read:
  - rdN = reg[raN], combinational, zero latency.
  - When ZERO_REG=1 and raN=0, rdN = 0 regardless of any other input.
  - When BYPASS=1 and we=1 and wa=raN (and the address is not the dropped zero register), rdN = wd in the same cycle.
- Scoreboard, next state for busy[a] at each edge, in priority order (highest first):
  1. flush=1 -> 0 for all a.
  2. iss_valid=1 and iss_addr=a -> 1. A new producer wins over a simultaneous writeback to the same address.
  3. we=1 and wa=a -> 0.
  4. Otherwise hold.
- Scoreboard edge cases:
  - Issue or writeback to register 0 with ZERO_REG=1 never sets busy[0]; busy[0] stays 0.
  - Writeback to a non-busy register is legal and leaves busy[a]=0.
  - Re-issue to an already-busy register keeps busy[a]=1; there is no depth count per register.
- Busy outputs:
  - busyN = busy[raN].
  - When BYPASS=1, busyN is forced to 0 if we=1 and wa=raN, unless iss_valid=1 and iss_addr=raN in the same cycle.
- pend_cnt:
  - Updated incrementally each edge: +1 when a busy bit goes 0->1, -1 when one goes 1->0. Both events on different addresses in one cycle give a net change of 0.
  - flush sets it to 0.
  - Invariant: pend_cnt equals the popcount of the busy bits after every edge. Range 0..2**ADDR_W; no wrap.
- No X propagation: all storage is reset and all outputs are defined in every cycle.

Decomposition:
- Package regfile_pkg:
  - default DATA_W/ADDR_W constants;
  - ZERO_ADDR constant;
  - function is_zero_reg(addr, ZERO_REG).
- One natural sub-module, regfile_scoreboard: busy vector, pend_cnt counter, set/clear/flush priority and busy output masking.
- Top level holds the storage array, the read/bypass muxing and the zero-register handling.

Test Plan:
- Reset with default parameters: drive rst_n=0 after writing reg5=0xDEADBEEF, with clk stopped -> rd1 with ra1=5 reads 0 immediately; busy1=0; pend_cnt=0.
- Write then read: we=1, wa=7, wd=0x12345678 -> same cycle rd2 (ra2=7) = 0x12345678 via bypass; next cycle with we=0 it still reads 0x12345678. With BYPASS=0, the same-cycle read returns the old value 0.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF, plus iss_valid=1, iss_addr=0 -> rd1 (ra1=0) = 0, busy1=0, pend_cnt stays 0.
- Scoreboard:
  - Issue r3 -> next cycle busy1(ra1=3)=1, pend_cnt=1.
  - Writeback r3 with wd=0xA5 -> that cycle busy1=0 and rd1=0xA5; next cycle pend_cnt=0.
- Collision: r9 busy; same cycle we=1, wa=9 and iss_valid=1, iss_addr=9 -> reg9 updated, busy stays 1, pend_cnt unchanged at 1.
- Flush and counter:
  - Issue r1, r2, r4 on consecutive cycles -> pend_cnt=3.
  - Then flush=1 together with iss_valid=1, iss_addr=6 -> all busy bits 0 and pend_cnt=0 (flush has priority).
